// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and line-level constants.
// Used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator shared by the TX framer and the RX checker.
// Even parity is the XOR-reduce of the data; odd parity is its inverse.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);

    assign parity = (par_typ == PAR_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, stop bit.
// CLK runs at the baud rate, so each FSM cycle is one bit time on TX_OUT.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

    uart_state_e           state;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic [DATA_WIDTH-1:0] data_sh;
    logic                  par_en_sh;
    logic                  par_typ_sh;
    logic                  par_bit_sh;
    logic                  par_bit_next;

    // Parity is computed from the live inputs and frozen at capture time.
    uart_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .parity  (par_bit_next)
    );

    // TX_OUT and Busy are loaded with the value belonging to the state being
    // entered, so both stay registered and line up with the state register.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            data_sh    <= '0;
            par_en_sh  <= 1'b0;
            par_typ_sh <= 1'b0;
            par_bit_sh <= 1'b0;
            TX_OUT     <= IDLE_LEVEL;
            Busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    TX_OUT <= IDLE_LEVEL;
                    Busy   <= 1'b0;
                    if (DATA_VALID) begin
                        data_sh    <= P_DATA;
                        par_en_sh  <= PAR_EN;
                        par_typ_sh <= PAR_TYP;
                        par_bit_sh <= par_bit_next;
                        state      <= START;
                        TX_OUT     <= START_BIT;
                        Busy       <= 1'b1;
                    end
                end
                START: begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    TX_OUT  <= data_sh[0];
                    Busy    <= 1'b1;
                end
                DATA: begin
                    Busy <= 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        if (par_en_sh) begin
                            state  <= PARITY;
                            TX_OUT <= par_bit_sh;
                        end else begin
                            state  <= STOP;
                            TX_OUT <= STOP_BIT;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        TX_OUT  <= data_sh[bit_cnt + 1'b1];
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    TX_OUT <= STOP_BIT;
                    Busy   <= 1'b1;
                end
                STOP: begin
                    // Leaving STOP always passes through one idle-high cycle.
                    state  <= IDLE;
                    TX_OUT <= IDLE_LEVEL;
                    Busy   <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= IDLE_LEVEL;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: stimulus pushes expected frames into a
// queue; a negedge monitor reassembles each Busy window and pops to compare.
module tb_uart_tx_frame;

    logic       clk;
    logic       rst_n;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    // Expected frame word: [15:12] Busy length, [10:0] serial bits, bit 0 first.
    logic [15:0] exp_q[$];

    uart_tx_frame #(
        .DATA_WIDTH(8),
        .CNT_WIDTH (3)
    ) dut (
        .CLK        (clk),
        .RST_n      (rst_n),
        .P_DATA     (p_data),
        .DATA_VALID (data_valid),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .TX_OUT     (tx_out),
        .Busy       (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [15:0] frame_word(input logic [7:0] d, input logic pe,
                                               input logic pb);
        logic [10:0] b;
        logic [3:0]  n;
        if (pe) begin
            b = {1'b1, pb, d, 1'b0};
            n = 4'd11;
        end else begin
            b = {1'b0, 1'b1, d, 1'b0};
            n = 4'd10;
        end
        return {n, 1'b0, b};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic check_lat);
        @(posedge clk);
        #1;
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        if (check_lat) begin
            check("latency_busy", {15'd0, busy}, 16'd1);
            check("latency_start", {15'd0, tx_out}, 16'd0);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 40);
        if (busy) check({name, "_timeout"}, {15'd0, busy}, 16'd0);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [15:0] cap_bits;
    int          cap_len;
    initial begin
        cap_bits = '0;
        cap_len  = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            cap_bits = '0;
            cap_len  = 0;
        end else if (busy) begin
            if (cap_len < 16) cap_bits[cap_len] = tx_out;
            cap_len++;
        end else if (cap_len != 0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", {cap_len[3:0], 1'b0, cap_bits[10:0]}, 16'd0);
            end else begin
                check("frame", {cap_len[3:0], 1'b0, cap_bits[10:0]}, exp_q.pop_front());
            end
            cap_bits = '0;
            cap_len  = 0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        p_data     = 8'h00;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        #12;
        check("reset_tx", {15'd0, tx_out}, 16'd1);
        check("reset_busy", {15'd0, busy}, 16'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // A5, no parity: 0,1,0,1,0,0,1,0,1,1 over 10 cycles
        exp_q.push_back(frame_word(8'hA5, 1'b0, 1'b0));
        send(8'hA5, 1'b0, 1'b0, 1'b1);
        wait_idle("a5_nopar");

        // A5 has four ones: even parity 0, odd parity 1
        exp_q.push_back(frame_word(8'hA5, 1'b1, 1'b0));
        send(8'hA5, 1'b1, 1'b0, 1'b1);
        wait_idle("a5_even");
        exp_q.push_back(frame_word(8'hA5, 1'b1, 1'b1));
        send(8'hA5, 1'b1, 1'b1, 1'b1);
        wait_idle("a5_odd");

        // 01 even -> 1; 00 odd -> 1
        exp_q.push_back(frame_word(8'h01, 1'b1, 1'b1));
        send(8'h01, 1'b1, 1'b0, 1'b1);
        wait_idle("01_even");
        exp_q.push_back(frame_word(8'h00, 1'b1, 1'b1));
        send(8'h00, 1'b1, 1'b1, 1'b1);
        wait_idle("00_odd");

        // 3C even parity (four ones -> 0); mid-frame strobe with FF is ignored
        exp_q.push_back(frame_word(8'h3C, 1'b1, 1'b0));
        send(8'h3C, 1'b1, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        p_data     = 8'hFF;
        par_en     = 1'b0;
        par_typ    = 1'b1;
        data_valid = 1'b1;
        @(posedge clk);
        #1 data_valid = 1'b0;
        wait_idle("3c_midframe");
        repeat (12) @(negedge clk);
        check("no_second_frame_busy", {15'd0, busy}, 16'd0);

        // DATA_VALID held: back-to-back 55 frames with one idle-high gap
        exp_q.push_back(frame_word(8'h55, 1'b0, 1'b0));
        exp_q.push_back(frame_word(8'h55, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        p_data     = 8'h55;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        data_valid = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (!busy && n < 5) begin @(negedge clk); n++; end
            n = 0;
            while (busy && n < 20) begin @(negedge clk); n++; end
            check("gap_tx", {15'd0, tx_out}, 16'd1);
            check("gap_busy", {15'd0, busy}, 16'd0);
            @(negedge clk);
            check("gap_next_busy", {15'd0, busy}, 16'd1);
            check("gap_next_start", {15'd0, tx_out}, 16'd0);
        end
        @(posedge clk);
        #1 data_valid = 1'b0;
        wait_idle("held_55");

        // Reset during data bit 4 abandons the frame immediately
        send(8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #2;
        check("pre_reset_busy", {15'd0, busy}, 16'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_tx", {15'd0, tx_out}, 16'd1);
        check("async_reset_busy", {15'd0, busy}, 16'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check("post_reset_idle", {14'd0, busy, tx_out}, 16'd1);
        end

        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
